// File: rtl/alu_sequencer.sv
// alu_sequencer
//   Command-level controller for the 4-bit ALU. It owns a 4-bit accumulator
//   and accepts one command per valid/ready handshake. A command either loads
//   the accumulator, does nothing (NOP), or applies one ALU operation to it
//   1-4 times in succession. The block then reports the final Z flag and a
//   sticky carry. The combinational ALU lives outside this block.
//
// Ports
//   clk, reset      rising-edge clock; synchronous active-high reset
//   cmd_valid       command present
//   cmd_ready       command accepted this cycle if cmd_valid (IDLE only)
//   cmd_op[3:0]     0000 LOAD, 0001-0111 NOP, 1000-1111 ALU opcode
//   cmd_b[3:0]      LOAD value or ALU operand b
//   cmd_rep[1:0]    ALU op repeats cmd_rep+1 times
//   alu_opcode/a/b  drive the external ALU (AND with b=0 outside EXEC)
//   alu_c/zf/cf     external ALU result and flags
//   acc[3:0]        accumulator
//   zf, cf          zero flag / sticky carry of the last completed command
//   busy            high in EXEC and DONE
//   done            one-cycle completion pulse
module alu_sequencer (
    input  logic       clk,
    input  logic       reset,
    input  logic       cmd_valid,
    output logic       cmd_ready,
    input  logic [3:0] cmd_op,
    input  logic [3:0] cmd_b,
    input  logic [1:0] cmd_rep,
    output logic [3:0] alu_opcode,
    output logic [3:0] alu_a,
    output logic [3:0] alu_b,
    input  logic [3:0] alu_c,
    input  logic       alu_zf,
    input  logic       alu_cf,
    output logic [3:0] acc,
    output logic       zf,
    output logic       cf,
    output logic       busy,
    output logic       done
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        EXEC = 2'd1,
        DONE = 2'd2
    } state_t;

    localparam logic [3:0] OP_LOAD = 4'b0000;
    localparam logic [3:0] OP_AND  = 4'b1000;

    state_t     state;
    logic [3:0] op_r;
    logic [3:0] b_r;
    logic [1:0] cnt_r;
    logic       cf_acc;

    always_ff @(posedge clk) begin
        if (reset) begin
            state  <= IDLE;
            acc    <= 4'd0;
            zf     <= 1'b1;
            cf     <= 1'b0;
            op_r   <= 4'd0;
            b_r    <= 4'd0;
            cnt_r  <= 2'd0;
            cf_acc <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (cmd_valid) begin
                        op_r   <= cmd_op;
                        b_r    <= cmd_b;
                        cnt_r  <= cmd_rep;
                        cf_acc <= 1'b0;
                        if (cmd_op[3]) begin
                            state <= EXEC;
                        end else begin
                            // LOAD commits immediately; NOP leaves acc and flags alone
                            if (cmd_op == OP_LOAD) begin
                                acc <= cmd_b;
                                zf  <= (cmd_b == 4'd0);
                                cf  <= 1'b0;
                            end
                            state <= DONE;
                        end
                    end
                end
                EXEC: begin
                    acc    <= alu_c;
                    cf_acc <= cf_acc | alu_cf;
                    if (cnt_r != 2'd0) begin
                        cnt_r <= cnt_r - 2'd1;
                    end else begin
                        // last iteration: zf from this result, cf sticky over all
                        zf    <= alu_zf;
                        cf    <= cf_acc | alu_cf;
                        state <= DONE;
                    end
                end
                DONE: begin
                    state <= IDLE;
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

    assign cmd_ready  = (state == IDLE);
    assign busy       = (state == EXEC) || (state == DONE);
    assign done       = (state == DONE);

    // ALU inputs come only from registered state, never from cmd_*
    assign alu_a      = acc;
    assign alu_opcode = (state == EXEC) ? op_r : OP_AND;
    assign alu_b      = (state == EXEC) ? b_r  : 4'd0;

endmodule

// File: tb/tb_alu_sequencer.sv
// tb_alu_sequencer
//   Drives alu_sequencer with directed and random commands, emulates the
//   external combinational ALU, and compares against a command-level model.
module tb_alu_sequencer;

    logic       clk;
    logic       reset;
    logic       cmd_valid;
    logic       cmd_ready;
    logic [3:0] cmd_op;
    logic [3:0] cmd_b;
    logic [1:0] cmd_rep;
    logic [3:0] alu_opcode;
    logic [3:0] alu_a;
    logic [3:0] alu_b;
    logic [3:0] alu_c;
    logic       alu_zf;
    logic       alu_cf;
    logic [3:0] acc;
    logic       zf;
    logic       cf;
    logic       busy;
    logic       done;

    int n_assert = 0;
    int n_fail   = 0;

    // command-level model state
    logic [3:0] acc_m;
    logic       zf_m;
    logic       cf_m;

    alu_sequencer dut (
        .clk        (clk),
        .reset      (reset),
        .cmd_valid  (cmd_valid),
        .cmd_ready  (cmd_ready),
        .cmd_op     (cmd_op),
        .cmd_b      (cmd_b),
        .cmd_rep    (cmd_rep),
        .alu_opcode (alu_opcode),
        .alu_a      (alu_a),
        .alu_b      (alu_b),
        .alu_c      (alu_c),
        .alu_zf     (alu_zf),
        .alu_cf     (alu_cf),
        .acc        (acc),
        .zf         (zf),
        .cf         (cf),
        .busy       (busy),
        .done       (done)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // external ALU stand-in
    logic [4:0] alu_t;
    always_comb begin
        alu_c  = 4'd0;
        alu_cf = 1'b0;
        alu_t  = 5'd0;
        case (alu_opcode)
            4'b1000: alu_c = alu_a & alu_b;
            4'b1001: alu_c = alu_a | alu_b;
            4'b1010: alu_c = alu_a ^ alu_b;
            4'b1011: alu_c = ~alu_a;
            4'b1100: begin
                alu_t  = {1'b0, alu_a} + 5'd1;
                alu_c  = alu_t[3:0];
                alu_cf = alu_t[4];
            end
            4'b1101: begin
                alu_t  = {1'b0, alu_a} - 5'd1;
                alu_c  = alu_t[3:0];
                alu_cf = alu_t[4];
            end
            4'b1110: begin
                alu_c  = {alu_a[2:0], 1'b0};
                alu_cf = alu_a[3];
            end
            4'b1111: begin
                alu_c  = {1'b0, alu_a[3:1]};
                alu_cf = alu_a[0];
            end
            default: ;
        endcase
    end
    assign alu_zf = (alu_c == 4'd0);

    // one ALU iteration in plain integer arithmetic: returns {carry, result}
    function automatic logic [4:0] ref_op(input logic [3:0] op, input logic [3:0] a,
                                          input logic [3:0] b);
        int   ai, bi, r;
        logic cy;
        ai = int'(a);
        bi = int'(b);
        cy = 1'b0;
        r  = ai;
        case (op)
            4'd8:  r = ai & bi;
            4'd9:  r = ai | bi;
            4'd10: r = ai ^ bi;
            4'd11: r = 15 - ai;
            4'd12: begin r = ai + 1; cy = (r == 16); r = r % 16; end
            4'd13: begin r = ai - 1; cy = (r < 0); r = (r + 16) % 16; end
            4'd14: begin r = ai * 2; cy = (r >= 16); r = r % 16; end
            4'd15: begin cy = ((ai % 2) != 0); r = ai / 2; end
            default: r = ai;
        endcase
        return {cy, r[3:0]};
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Issue one command from IDLE and follow it to the following IDLE cycle.
    // With keep set, cmd_valid stays high carrying the next command.
    task automatic run_cmd(input logic [3:0] op, input logic [3:0] b, input logic [1:0] rep,
                           input bit keep, input logic [3:0] nop, input logic [3:0] nb,
                           input logic [1:0] nrep);
        int         n_exec;
        logic [4:0] r;
        logic       cfa;
        chk("idle_ready", 32'(cmd_ready), 32'd1);
        chk("idle_busy", 32'(busy), 32'd0);
        cmd_valid = 1'b1;
        cmd_op    = op;
        cmd_b     = b;
        cmd_rep   = rep;
        step();
        if (keep) begin
            cmd_op  = nop;
            cmd_b   = nb;
            cmd_rep = nrep;
        end else begin
            cmd_valid = 1'b0;
        end
        n_exec = op[3] ? int'(rep) + 1 : 0;
        cfa    = 1'b0;
        for (int k = 0; k < n_exec; k++) begin
            chk("exec_busy", 32'(busy), 32'd1);
            chk("exec_ready", 32'(cmd_ready), 32'd0);
            chk("exec_done", 32'(done), 32'd0);
            chk("exec_opcode", 32'(alu_opcode), 32'(op));
            chk("exec_alu_b", 32'(alu_b), 32'(b));
            chk("exec_alu_a", 32'(alu_a), 32'(acc_m));
            chk("exec_acc", 32'(acc), 32'(acc_m));
            r     = ref_op(op, acc_m, b);
            acc_m = r[3:0];
            cfa   = cfa | r[4];
            step();
        end
        if (op == 4'd0) begin
            acc_m = b;
            zf_m  = (b == 4'd0);
            cf_m  = 1'b0;
        end else if (op[3]) begin
            zf_m = (acc_m == 4'd0);
            cf_m = cfa;
        end
        chk("done_pulse", 32'(done), 32'd1);
        chk("done_busy", 32'(busy), 32'd1);
        chk("done_ready", 32'(cmd_ready), 32'd0);
        chk("done_acc", 32'(acc), 32'(acc_m));
        chk("done_zf", 32'(zf), 32'(zf_m));
        chk("done_cf", 32'(cf), 32'(cf_m));
        chk("done_opcode", 32'(alu_opcode), 32'h8);
        chk("done_alu_b", 32'(alu_b), 32'd0);
        step();
        chk("after_done", 32'(done), 32'd0);
        chk("after_ready", 32'(cmd_ready), 32'd1);
        chk("after_busy", 32'(busy), 32'd0);
        chk("after_acc", 32'(acc), 32'(acc_m));
        chk("after_zf", 32'(zf), 32'(zf_m));
        chk("after_cf", 32'(cf), 32'(cf_m));
        chk("after_opcode", 32'(alu_opcode), 32'h8);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        reset     = 1'b1;
        cmd_valid = 1'b0;
        cmd_op    = 4'd0;
        cmd_b     = 4'd0;
        cmd_rep   = 2'd0;
        acc_m     = 4'd0;
        zf_m      = 1'b1;
        cf_m      = 1'b0;
        step();
        step();
        reset = 1'b0;
        step();
        step();
        step();
        chk("rst_acc", 32'(acc), 32'd0);
        chk("rst_zf", 32'(zf), 32'd1);
        chk("rst_cf", 32'(cf), 32'd0);
        chk("rst_ready", 32'(cmd_ready), 32'd1);
        chk("rst_done", 32'(done), 32'd0);
        chk("rst_busy", 32'(busy), 32'd0);
        chk("rst_opcode", 32'(alu_opcode), 32'h8);
        chk("rst_alu_b", 32'(alu_b), 32'd0);

        // LOAD F, INC once -> wraps to 0 with carry
        run_cmd(4'd0, 4'hF, 2'd0, 1'b0, 4'd0, 4'd0, 2'd0);
        run_cmd(4'hC, 4'h0, 2'd0, 1'b0, 4'd0, 4'd0, 2'd0);
        chk("inc_wrap_acc", 32'(acc), 32'd0);
        chk("inc_wrap_cf", 32'(cf), 32'd1);

        // LOAD 3, SHL x4 -> 6, C, 8, 0
        run_cmd(4'd0, 4'h3, 2'd0, 1'b0, 4'd0, 4'd0, 2'd0);
        run_cmd(4'hE, 4'h0, 2'd3, 1'b0, 4'd0, 4'd0, 2'd0);
        chk("shl_acc", 32'(acc), 32'd0);
        chk("shl_zf", 32'(zf), 32'd1);
        chk("shl_cf", 32'(cf), 32'd1);

        // LOAD 0, DEC x2 -> F then E, carry sticky from first borrow
        run_cmd(4'd0, 4'h0, 2'd0, 1'b0, 4'd0, 4'd0, 2'd0);
        run_cmd(4'hD, 4'h0, 2'd1, 1'b0, 4'd0, 4'd0, 2'd0);
        chk("dec_acc", 32'(acc), 32'hE);
        chk("dec_zf", 32'(zf), 32'd0);
        chk("dec_cf", 32'(cf), 32'd1);

        // NOP leaves acc and flags unchanged
        run_cmd(4'd5, 4'h9, 2'd3, 1'b0, 4'd0, 4'd0, 2'd0);
        chk("nop_acc", 32'(acc), 32'hE);

        // XOR b=5 held during a rep=2 AND that leaves acc=A
        run_cmd(4'd0, 4'hA, 2'd0, 1'b0, 4'd0, 4'd0, 2'd0);
        run_cmd(4'h8, 4'hF, 2'd2, 1'b1, 4'hA, 4'h5, 2'd0);
        run_cmd(4'hA, 4'h5, 2'd0, 1'b0, 4'd0, 4'd0, 2'd0);
        chk("held_acc", 32'(acc), 32'hF);
        chk("held_zf", 32'(zf), 32'd0);
        chk("held_cf", 32'(cf), 32'd0);

        // reset in the second EXEC cycle of SHR rep=3
        run_cmd(4'd0, 4'h9, 2'd0, 1'b0, 4'd0, 4'd0, 2'd0);
        cmd_valid = 1'b1;
        cmd_op    = 4'hF;
        cmd_b     = 4'h0;
        cmd_rep   = 2'd3;
        step();
        cmd_valid = 1'b0;
        chk("rst_exec1_busy", 32'(busy), 32'd1);
        step();
        chk("rst_exec2_acc", 32'(acc), 32'h4);
        reset = 1'b1;
        step();
        reset = 1'b0;
        acc_m = 4'd0;
        zf_m  = 1'b1;
        cf_m  = 1'b0;
        chk("abort_done", 32'(done), 32'd0);
        chk("abort_busy", 32'(busy), 32'd0);
        chk("abort_ready", 32'(cmd_ready), 32'd1);
        chk("abort_acc", 32'(acc), 32'd0);
        chk("abort_zf", 32'(zf), 32'd1);
        chk("abort_cf", 32'(cf), 32'd0);
        step();
        chk("abort_no_done", 32'(done), 32'd0);
        run_cmd(4'd0, 4'h7, 2'd0, 1'b0, 4'd0, 4'd0, 2'd0);
        chk("reload_acc", 32'(acc), 32'h7);

        // random commands against the model
        for (int i = 0; i < 60; i++) begin
            logic [3:0] rop;
            logic [3:0] rb;
            logic [1:0] rrep;
            rop  = 4'($urandom_range(0, 15));
            if ($urandom_range(0, 3) == 0) rop = 4'd0;
            rb   = 4'($urandom_range(0, 15));
            rrep = 2'($urandom_range(0, 3));
            run_cmd(rop, rb, rrep, 1'b0, 4'd0, 4'd0, 2'd0);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule

// File: doc/alu_sequencer.md
# alu_sequencer

Command-level controller for the 4-bit ALU. It owns a 4-bit accumulator and accepts one command per valid/ready handshake. Each command either loads the accumulator or applies one ALU operation to it 1-4 times in succession, and the block reports the final Z/C flags. It sits between the instruction decode of the MACH64 core and the combinational ALU, which is instantiated outside this block and wired to the alu_* ports.

## Interface
Parameters: none; all widths are fixed at 4 bits.

Ports:
- clk  in  1  single clock; all state changes on the rising edge
- reset  in  1  synchronous, active-high reset
- cmd_valid  in  1  command present
- cmd_ready  out  1  block can accept a command (IDLE only)
- cmd_op  in  4  0000 = LOAD; 0001-0111 = NOP; 1000-1111 = ALU opcode (AND, OR, XOR, NOT_A, INC_A, DEC_A, SHL_A, SHR_A)
- cmd_b  in  4  LOAD value, or ALU operand b
- cmd_rep  in  2  ALU op executes cmd_rep+1 times (1-4); ignored for LOAD/NOP
- alu_opcode  out  4  to ALU opcode
- alu_a  out  4  to ALU a; always equals acc
- alu_b  out  4  to ALU b
- alu_c  in  4  ALU result
- alu_zf  in  1  ALU zero flag
- alu_cf  in  1  ALU carry flag
- acc  out  4  accumulator
- zf  out  1  zero flag of the last completed command
- cf  out  1  sticky carry of the last completed command
- busy  out  1  high in EXEC and DONE
- done  out  1  one-cycle completion pulse

## Operation
- States are IDLE, EXEC and DONE. Reset forces IDLE, acc=0, zf=1, cf=0, done=0, busy=0 and clears internal op_r, b_r, cnt_r and cf_acc.
- IDLE:
  - cmd_ready=1.
  - On cmd_valid=1, capture op_r=cmd_op, b_r=cmd_b, cnt_r=cmd_rep and clear cf_acc.
  - cmd_op[3]=1: go to EXEC.
  - LOAD: at the same edge, acc<=cmd_b, zf<=(cmd_b==0), cf<=0; go to DONE.
  - NOP: acc, zf and cf are unchanged; go to DONE.
- EXEC:
  - alu_opcode=op_r, alu_b=b_r.
  - Each edge: acc<=alu_c, cf_acc<=cf_acc|alu_cf.
  - cnt_r!=0: cnt_r<=cnt_r-1 and stay in EXEC.
  - cnt_r==0 (last iteration): zf<=alu_zf, cf<=cf_acc|alu_cf; go to DONE.
- DONE: done=1 for exactly one cycle, then go to IDLE.
- Outside EXEC: alu_opcode=4'b1000 (AND) and alu_b=0. The ALU result is ignored there.
- cmd_ready=0 in EXEC and DONE. cmd_valid is ignored in those states, and a command held through them is accepted in the next IDLE cycle.
- zf reflects the final result only. cf is the OR of every iteration's carry: INC wrap, DEC borrow, or the bit shifted out by SHL/SHR.
- All arithmetic is modulo 16. The accumulator wraps without saturating.
- Reset asserted in any state takes priority over everything:
  - The command is abandoned and done is not pulsed.
  - The next cycle is IDLE with reset values.

## Timing
- Command accepted at the edge ending cycle C0.
- ALU op: EXEC occupies C1..C(rep+1); done=1 in C(rep+2); acc, zf and cf are valid from C(rep+2).
- LOAD/NOP: done=1 in C1; acc and flags valid from C1.
- Back-to-back issue: the earliest next acceptance is in cycle C(rep+3) for an ALU op, or C2 for LOAD/NOP. Throughput is therefore one command per rep+3 cycles (ALU op) or per 2 cycles (LOAD/NOP).
- cmd_ready, busy and done are decoded from registered state only. alu_* outputs are combinational from state, op_r, b_r and acc.
- There is no combinational path from cmd_* to alu_*.

## Test plan
- Reset, then idle 3 cycles -> acc=0, zf=1, cf=0, cmd_ready=1, done=0, alu_opcode=1000.
- LOAD b=F, then INC_A rep=0 -> INC done one cycle after its single EXEC cycle; acc=0, zf=1, cf=1.
- LOAD 3, then SHL_A rep=3 -> EXEC for 4 cycles, acc sequence 6, C, 8, 0; done in C5; acc=0, zf=1, cf=1.
- LOAD 0, then DEC_A rep=1 -> acc F then E; zf=0, cf=1 (sticky from the first borrow).
- Hold cmd_valid high with XOR b=5 on acc=A during a rep=2 command -> cmd_ready=0 throughout EXEC/DONE. The held command is accepted only in the next IDLE cycle; acc=F, zf=0, cf=0.
- Assert reset in the second EXEC cycle of an SHR_A rep=3 command -> no done pulse; the next cycle shows acc=0, zf=1, cf=0, IDLE. A new LOAD 7 completes normally.
